keypad_debounce: RTL and testbench

Debounces and encodes the 10-line active-low digit keypad, feeding the watch/time-setting logic with clean, single-cycle key events instead of raw key levels. It sits directly between the board keypad pins and the clock/setting block, on the same 1 kHz system clock. It also provides optional typematic repeat and flags illegal multi-key presses.

---
 rtl/keypad_debounce.sv | 170 +++++++++++++++++
 tb/tb_keypad_debounce.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/keypad_debounce.sv
// rtl/keypad_debounce.sv - debounced, encoded 10-key keypad with typematic repeat and multi-key flag
module keypad_debounce #(
    parameter int DEBOUNCE_CYC = 20,
    parameter int REPEAT_DELAY = 0,
    parameter int REPEAT_RATE  = 200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] keypad,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held,
    output logic       key_err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DEBOUNCE,
        S_HELD,
        S_RELEASE
    } state_t;

    // Terminal counts are precomputed in 16 bits so maximum parameters never overflow.
    localparam logic [15:0] DEB_LAST  = 16'(DEBOUNCE_CYC - 1);
    localparam logic [15:0] DLY_LAST  = 16'(REPEAT_DELAY - 1);
    localparam logic [15:0] RATE_LAST = 16'(REPEAT_RATE - 1);
    localparam bit          REP_EN    = (REPEAT_DELAY != 0);
    localparam logic [9:0]  NO_KEY    = 10'h3FF;

    logic [9:0]  sync1_q, sync2_q;
    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] rep_cnt_q, rep_cnt_d;
    logic        first_q, first_d;
    logic [9:0]  cand_q, cand_d;
    logic [3:0]  code_q, code_d;
    logic        valid_q, valid_d;
    logic        held_q, held_d;
    logic        err_q;

    logic [3:0]  zero_cnt;
    logic        pat_none, pat_single, pat_multi;
    logic [3:0]  cand_idx;
    logic [15:0] rep_last;

    // Count low lines of the synchronized pattern to classify it.
    always_comb begin
        zero_cnt = 4'd0;
        for (int i = 0; i < 10; i++) begin
            zero_cnt = zero_cnt + {3'b000, ~sync2_q[i]};
        end
    end

    assign pat_none   = (sync2_q == NO_KEY);
    assign pat_single = (zero_cnt == 4'd1);
    assign pat_multi  = (zero_cnt >= 4'd2);

    // Encode the digit of the (single-zero) candidate pattern.
    always_comb begin
        cand_idx = 4'd0;
        for (int i = 9; i >= 0; i--) begin
            if (!cand_q[i]) begin
                cand_idx = 4'(i);
            end
        end
    end

    assign rep_last = first_q ? DLY_LAST : RATE_LAST;

    // Two-flop synchronizer on the raw pins plus the multi-key error level.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= NO_KEY;
            sync2_q <= NO_KEY;
            err_q   <= 1'b0;
        end else begin
            sync1_q <= keypad;
            sync2_q <= sync1_q;
            err_q   <= pat_multi;
        end
    end

    // FSM and datapath register bank.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= 16'd0;
            rep_cnt_q <= 16'd0;
            first_q   <= 1'b0;
            cand_q    <= NO_KEY;
            code_q    <= 4'd0;
            valid_q   <= 1'b0;
            held_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rep_cnt_q <= rep_cnt_d;
            first_q   <= first_d;
            cand_q    <= cand_d;
            code_q    <= code_d;
            valid_q   <= valid_d;
            held_q    <= held_d;
        end
    end

    // Next-state logic: accept a press after a stable run, repeat while held,
    // and require a full debounced release before the next key (no rollover).
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rep_cnt_d = rep_cnt_q;
        first_d   = first_q;
        cand_d    = cand_q;
        code_d    = code_q;
        valid_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (pat_single) begin
                    cand_d  = sync2_q;
                    cnt_d   = 16'd0;
                    state_d = S_DEBOUNCE;
                end
            end
            S_DEBOUNCE: begin
                if (sync2_q != cand_q) begin
                    state_d = S_IDLE;
                end else if (cnt_q == DEB_LAST) begin
                    state_d   = S_HELD;
                    valid_d   = 1'b1;
                    code_d    = cand_idx;
                    rep_cnt_d = 16'd0;
                    first_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_HELD: begin
                if (sync2_q != cand_q) begin
                    state_d = S_RELEASE;
                    cnt_d   = 16'd0;
                end else if (REP_EN) begin
                    if (rep_cnt_q == rep_last) begin
                        valid_d   = 1'b1;
                        rep_cnt_d = 16'd0;
                        first_d   = 1'b0;
                    end else begin
                        rep_cnt_d = rep_cnt_q + 16'd1;
                    end
                end
            end
            S_RELEASE: begin
                if (!pat_none) begin
                    cnt_d = 16'd0;
                end else if (cnt_q == DEB_LAST) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        held_d = (state_d == S_HELD);
    end

    assign key_code  = code_q;
    assign key_valid = valid_q;
    assign key_held  = held_q;
    assign key_err   = err_q;

endmodule

// File: tb/tb_keypad_debounce.sv
// tb/tb_keypad_debounce.sv - scoreboard bench for keypad_debounce
module tb_keypad_debounce;

    localparam logic [9:0] NONE = 10'h3FF;
    localparam logic [9:0] K0   = 10'h3FE;
    localparam logic [9:0] K1   = 10'h3FD;
    localparam logic [9:0] K12  = 10'h3F9;
    localparam logic [9:0] K3   = 10'h3F7;
    localparam logic [9:0] K4   = 10'h3EF;
    localparam logic [9:0] K5   = 10'h3DF;
    localparam logic [9:0] K7   = 10'h37F;
    localparam logic [9:0] K9   = 10'h1FF;

    logic       clk = 1'b0;
    int         cyc = 0;
    int         n_pass = 0;
    int         n_total = 0;

    logic       rst_a, rst_r, rst_m;
    logic [9:0] kp_a, kp_r, kp_m;
    logic [3:0] kc_a, kc_r, kc_m;
    logic       kv_a, kv_r, kv_m;
    logic       kh_a, kh_r, kh_m;
    logic       ke_a, ke_r, ke_m;

    typedef struct {
        int inst;
        int cyc;
        int code;
    } exp_t;
    exp_t sb[$];

    keypad_debounce #(.DEBOUNCE_CYC(20), .REPEAT_DELAY(0), .REPEAT_RATE(200)) u_a (
        .clk(clk), .rst(rst_a), .keypad(kp_a),
        .key_code(kc_a), .key_valid(kv_a), .key_held(kh_a), .key_err(ke_a));

    keypad_debounce #(.DEBOUNCE_CYC(20), .REPEAT_DELAY(50), .REPEAT_RATE(10)) u_r (
        .clk(clk), .rst(rst_r), .keypad(kp_r),
        .key_code(kc_r), .key_valid(kv_r), .key_held(kh_r), .key_err(ke_r));

    keypad_debounce #(.DEBOUNCE_CYC(1), .REPEAT_DELAY(0), .REPEAT_RATE(200)) u_m (
        .clk(clk), .rst(rst_m), .keypad(kp_m),
        .key_code(kc_m), .key_valid(kv_m), .key_held(kh_m), .key_err(ke_m));

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int got, input int exp);
        n_total++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
    endtask

    task automatic expect_ev(input int inst, input int c, input int code);
        exp_t e;
        e.inst = inst;
        e.cyc  = c;
        e.code = code;
        sb.push_back(e);
    endtask

    task automatic mon_pop(input int inst, input logic [3:0] code);
        exp_t e;
        check("event_expected", int'(sb.size() > 0), 1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check("event_inst", inst, e.inst);
            check("event_cycle", cyc, e.cyc);
            check("event_code", int'(code), e.code);
        end
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    // Monitor: every key_valid pulse is matched against the head of the scoreboard.
    always @(negedge clk) begin
        if (kv_a) mon_pop(0, kc_a);
        if (kv_r) mon_pop(1, kc_r);
        if (kv_m) mon_pop(2, kc_m);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int e0, e1, t, tr;
        rst_a = 1'b0; rst_r = 1'b0; rst_m = 1'b0;
        kp_a = K12; kp_r = NONE; kp_m = NONE;
        repeat (3) @(negedge clk);
        check("reset_code", int'(kc_a), 0);
        check("reset_valid", int'(kv_a), 0);
        check("reset_held", int'(kh_a), 0);
        check("reset_err_a", int'(ke_a), 0);
        check("reset_err_r", int'(ke_r), 0);
        check("reset_err_m", int'(ke_m), 0);
        kp_a = NONE;
        @(negedge clk);
        rst_a = 1'b1; rst_r = 1'b1; rst_m = 1'b1;
        repeat (5) @(negedge clk);

        // Clean press of key 3, release after 100 cycles.
        e0 = cyc + 1;
        kp_a = K3;
        expect_ev(0, e0 + 22, 3);
        wait_until(e0 + 21); check("press_held_before", int'(kh_a), 0);
        wait_until(e0 + 22); check("press_held_rise", int'(kh_a), 1);
        check("press_code", int'(kc_a), 3);
        wait_until(e0 + 99); kp_a = NONE;
        wait_until(e0 + 101); check("release_held_still", int'(kh_a), 1);
        wait_until(e0 + 102); check("release_held_fall", int'(kh_a), 0);
        check("release_code_holds", int'(kc_a), 3);
        wait_until(e0 + 130);

        // Bouncing key 7, then stable.
        for (int i = 0; i < 8; i++) begin
            kp_a = (i % 2 == 0) ? K7 : NONE;
            repeat (5) @(negedge clk);
        end
        e0 = cyc + 1;
        kp_a = K7;
        expect_ev(0, e0 + 22, 7);
        wait_until(e0 + 60); kp_a = NONE;
        wait_until(e0 + 100);

        // Multi-key press: error flag, no event.
        t = cyc;
        kp_a = K12;
        wait_until(t + 30);
        check("multi_err", int'(ke_a), 1);
        check("multi_no_held", int'(kh_a), 0);
        kp_a = NONE;
        wait_until(t + 40);
        check("multi_err_clear", int'(ke_a), 0);

        // Rollover 1 -> 5: no code-5 event until a full debounced release.
        e0 = cyc + 1;
        kp_a = K1;
        expect_ev(0, e0 + 22, 1);
        wait_until(e0 + 40); check("roll_held_k1", int'(kh_a), 1);
        kp_a = K5;
        wait_until(e0 + 42); check("roll_held_still", int'(kh_a), 1);
        wait_until(e0 + 43); check("roll_held_drop", int'(kh_a), 0);
        wait_until(e0 + 70); kp_a = NONE;
        wait_until(e0 + 80); kp_a = K5;
        wait_until(e0 + 110);
        check("roll_no_held_k5", int'(kh_a), 0);
        check("roll_code_k1", int'(kc_a), 1);
        t = cyc;
        kp_a = NONE;
        wait_until(t + 25);
        e1 = cyc + 1;
        kp_a = K5;
        expect_ev(0, e1 + 22, 5);
        wait_until(e1 + 22); check("roll_code_k5", int'(kc_a), 5);
        wait_until(e1 + 30); kp_a = NONE;
        wait_until(e1 + 60);

        // Reset mid-debounce with the key still pressed.
        e0 = cyc + 1;
        kp_a = K4;
        wait_until(e0 + 12);
        rst_a = 1'b0;
        #1;
        check("midrst_code", int'(kc_a), 0);
        check("midrst_valid", int'(kv_a), 0);
        check("midrst_held", int'(kh_a), 0);
        check("midrst_err", int'(ke_a), 0);
        repeat (3) @(negedge clk);
        rst_a = 1'b1;
        tr = cyc;
        expect_ev(0, tr + 23, 4);
        wait_until(tr + 23);
        check("midrst_held_after", int'(kh_a), 1);
        check("midrst_code_after", int'(kc_a), 4);
        wait_until(tr + 40); kp_a = NONE;
        wait_until(tr + 80);

        // Typematic repeat on key 9.
        e0 = cyc + 1;
        kp_r = K9;
        expect_ev(1, e0 + 22, 9);
        expect_ev(1, e0 + 72, 9);
        expect_ev(1, e0 + 82, 9);
        expect_ev(1, e0 + 92, 9);
        expect_ev(1, e0 + 102, 9);
        expect_ev(1, e0 + 112, 9);
        wait_until(e0 + 72); check("rep_held", int'(kh_r), 1);
        wait_until(e0 + 113); kp_r = NONE;
        wait_until(e0 + 115); check("rep_held_still", int'(kh_r), 1);
        wait_until(e0 + 116); check("rep_held_fall", int'(kh_r), 0);
        wait_until(e0 + 150);

        // Minimum debounce: one-sample glitch ignored, two-cycle press accepted.
        kp_m = K0;
        @(negedge clk);
        kp_m = NONE;
        repeat (10) @(negedge clk);
        e0 = cyc + 1;
        kp_m = K0;
        expect_ev(2, e0 + 3, 0);
        @(negedge clk);
        @(negedge clk);
        kp_m = NONE;
        wait_until(e0 + 3); check("min_held", int'(kh_m), 1);
        wait_until(e0 + 4); check("min_held_fall", int'(kh_m), 0);
        wait_until(e0 + 20);

        check("scoreboard_empty", int'(sb.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
